// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - pause/run/adjust control and BCD MM:SS counter for the stopwatch.
// Every output is a flop; clr_pulse overrides any increment sampled in the same cycle.
module stopwatch_core #(
  parameter int MIN_LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  input  logic       pause_pulse,
  input  logic       clr_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       wrap
);

  localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;

  logic run_inc, adj_sec, adj_min, step_sec, step_min, sec_max, min_max;

  always_comb begin
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    wrap_d     = 1'b0;

    sec_max  = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
    min_max  = (min_tens_q == LIM_TENS) && (min_ones_q == LIM_ONES);
    run_inc  = (state_q == ST_RUN) && tick_1hz;
    adj_sec  = (state_q == ST_ADJUST) && tick_adj && sel;
    adj_min  = (state_q == ST_ADJUST) && tick_adj && !sel;
    // In ADJUST the seconds field wraps without carrying into minutes.
    step_sec = run_inc || adj_sec;
    step_min = (run_inc && sec_max) || adj_min;

    if (step_sec) begin
      if (sec_ones_q == 4'd9) begin
        sec_ones_d = 4'd0;
        sec_tens_d = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end

    if (step_min) begin
      if (min_max) begin
        min_tens_d = 4'd0;
        min_ones_d = 4'd0;
        wrap_d     = run_inc;
      end else if (min_ones_q == 4'd9) begin
        min_ones_d = 4'd0;
        min_tens_d = min_tens_q + 4'd1;
      end else begin
        min_ones_d = min_ones_q + 4'd1;
      end
    end

    if (clr_pulse) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
      wrap_d     = 1'b0;
    end

    case (state_q)
      ST_PAUSE:  if (adj) state_d = ST_ADJUST; else if (pause_pulse) state_d = ST_RUN;
      ST_RUN:    if (adj) state_d = ST_ADJUST; else if (pause_pulse) state_d = ST_PAUSE;
      ST_ADJUST: if (!adj) state_d = ST_PAUSE;
      default:   state_d = ST_PAUSE;
    endcase

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PAUSE;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign running  = running_q;
  assign wrap     = wrap_q;

endmodule
